// File: rtl/t03_bus_pkg.sv
// Shared types for the CPU-side Wishbone arbiter: FSM states, port ids, full byte-select.
package t03_bus_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} arb_state_t;
  typedef enum logic {PORT_F = 1'b0, PORT_D = 1'b1} port_t;
  localparam logic [3:0] FULL_SEL = 4'hF;
endpackage

// File: rtl/t03_rr_arb2.sv
// Combinational two-way round-robin pick; eligible[0] = fetch, eligible[1] = data.
module t03_rr_arb2
  import t03_bus_pkg::*;
(
  input  logic [1:0] eligible,
  input  port_t      last,
  output logic       grant_vld,
  output port_t      grant
);
  always_comb begin
    grant_vld = |eligible;
    grant     = PORT_F;
    if (eligible == 2'b11) begin
      grant = (last == PORT_F) ? PORT_D : PORT_F;
    end else if (eligible[1]) begin
      grant = PORT_D;
    end
  end
endmodule

// File: rtl/t03_wb_arbiter.sv
// Shares one Wishbone manager user port between fetch (read-only) and data (read/write) ports.
// Round-robin grant, one-cycle strobe, waits for ACK, returns a one-cycle DONE to the winner.
module t03_wb_arbiter
  import t03_bus_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter bit FETCH_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              F_REQ,
  input  logic [ADDR_W-1:0] F_ADR,
  output logic              F_DONE,
  output logic [DATA_W-1:0] F_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADR,
  input  logic [DATA_W-1:0] D_WDATA,
  input  logic [3:0]        D_SEL,
  output logic              D_DONE,
  output logic [DATA_W-1:0] D_RDATA,
  output logic [ADDR_W-1:0] M_ADR,
  output logic [DATA_W-1:0] M_WDATA,
  output logic [3:0]        M_SEL,
  output logic              M_WRITE,
  output logic              M_READ,
  input  logic [DATA_W-1:0] M_RDATA,
  input  logic              M_BUSY,
  input  logic              M_ACK
);
  arb_state_t state;
  port_t      cur;
  port_t      last;
  logic       cur_we;
  logic [1:0] eligible;
  logic       grant_vld;
  port_t      grant;

  // A DONE still showing means that port's REQ is stale for this cycle.
  assign eligible = {D_REQ & ~D_DONE, F_REQ & ~F_DONE};

  t03_rr_arb2 u_rr (
    .eligible  (eligible),
    .last      (last),
    .grant_vld (grant_vld),
    .grant     (grant)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cur     <= PORT_F;
      cur_we  <= 1'b0;
      last    <= FETCH_FIRST ? PORT_D : PORT_F;
      F_DONE  <= 1'b0;
      D_DONE  <= 1'b0;
      F_RDATA <= '0;
      D_RDATA <= '0;
      M_ADR   <= '0;
      M_WDATA <= '0;
      M_SEL   <= '0;
      M_WRITE <= 1'b0;
      M_READ  <= 1'b0;
    end else begin
      F_DONE <= 1'b0;
      D_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (!M_BUSY && grant_vld) begin
            cur   <= grant;
            state <= ISSUE;
            if (grant == PORT_F) begin
              M_ADR   <= F_ADR;
              M_WDATA <= '0;
              M_SEL   <= FULL_SEL;
              cur_we  <= 1'b0;
              M_READ  <= 1'b1;
              M_WRITE <= 1'b0;
            end else begin
              M_ADR   <= D_ADR;
              M_WDATA <= D_WDATA;
              M_SEL   <= D_SEL;
              cur_we  <= D_WE;
              M_READ  <= ~D_WE;
              M_WRITE <= D_WE;
            end
          end
        end
        ISSUE: begin
          M_READ  <= 1'b0;
          M_WRITE <= 1'b0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (M_ACK) state <= RESP;
        end
        RESP: begin
          if (cur == PORT_F) begin
            F_DONE  <= 1'b1;
            F_RDATA <= M_RDATA;
          end else begin
            D_DONE <= 1'b1;
            if (!cur_we) D_RDATA <= M_RDATA;
          end
          last  <= cur;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
